// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO result registers.
// Each multiply or divide takes one bit per cycle. The latency is fixed at
// WIDTH+1 edges after the accepting edge: WIDTH RUN cycles followed by one
// FIX cycle that applies the sign and writes the result.
//
// Ports:
//   clk    - single clock, rising edge
//   reset  - synchronous, active-high
//   start  - request strobe, accepted only while idle (busy=0)
//   op     - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//            110/111 no-op
//   a, b   - operands (a also carries the MTHI/MTLO data)
//   busy   - a multiply or divide is in flight
//   done   - one-cycle pulse after the result is written to hi/lo
//   hi, lo - HI: product upper half or remainder; LO: product lower half
//            or quotient
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     dv_q, dv_d;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   acc_q, acc_d;    // product, or {remainder, quotient}
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    // Magnitude of x; the most-negative value maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                             input logic sgn);
        mag = (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    // Datapath step signals
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_rem;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic                 sgn_op;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;

    always_comb begin
        // Shift-add: add the multiplicand into the upper half when the
        // current multiplier bit (LSB) is set, then shift right with carry.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, dv_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring division: shift the next dividend bit into the partial
        // remainder, subtract if it fits, and shift the quotient bit in.
        div_rem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_rem - {1'b0, dv_q};
        div_ge   = (div_rem >= {1'b0, dv_q});
        div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0]),
                    acc_q[WIDTH-2:0], div_ge};

        sgn_op = ~op[0];
        mag_a  = mag(a, sgn_op);
        mag_b  = mag(b, sgn_op);

        prod = (!op_q[0] && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? (~acc_q + 1'b1) : acc_q;
        quo  = (!op_q[0] && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ?
               (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem  = (!op_q[0] && a_q[WIDTH-1]) ?
               (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        dv_d    = dv_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            op_d    = op;
                            a_d     = a;
                            b_d     = b;
                            cnt_d   = CW'(WIDTH);
                            state_d = S_RUN;
                            if (op[1]) begin
                                dv_d  = mag_b;
                                acc_d = {{WIDTH{1'b0}}, mag_a};
                            end else begin
                                dv_d  = mag_a;
                                acc_d = {{WIDTH{1'b0}}, mag_b};
                            end
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                acc_d = op_q[1] ? div_next : mul_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (!op_q[1]) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (b_q == '0) begin
                    // Divide by zero: raw dividend in HI, all ones in LO.
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Operand and accumulator registers carry no reset; they are always
    // loaded before use.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        a_q   <= a_d;
        b_q   <= b_d;
        dv_q  <= dv_d;
        acc_q <= acc_d;
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width; legal range 4..64.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request strobe; sampled only at a rising edge.
REQ-005 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
REQ-006 a  input  WIDTH  multiplicand / dividend / MTHI-MTLO data.
REQ-007 b  input  WIDTH  multiplier / divisor.
REQ-008 busy  output  1  high while a multiply or divide is in flight.
REQ-009 done  output  1  one-cycle pulse when a multiply or divide result is written.
REQ-010 hi  output  WIDTH  HI register: product upper half or remainder.
REQ-011 lo  output  WIDTH  LO register: product lower half or quotient.

Function
REQ-012 Iterative engine, one bit per cycle; states IDLE, RUN, FIX.
REQ-013 Accept start only in IDLE with busy=0; ignore start, op, a and b while busy=1 (no queuing, no restart).
REQ-014 On accepted MULT/MULTU/DIV/DIVU at edge E0: latch a, b and op; state goes to RUN; busy=1 after E0; later input changes have no effect.
REQ-015 RUN lasts exactly WIDTH cycles (edges E0+1..E0+WIDTH), controlled by a down-counter loaded with WIDTH; then state goes to FIX.
REQ-016 At FIX edge E0+WIDTH+1: write hi/lo; done=1 and busy=0 for the following cycle; state returns to IDLE.
REQ-017 Fixed latency: done visible exactly WIDTH+1 edges after the accepting edge, for every operand value.
REQ-018 Back-to-back: a start sampled while done=1 is accepted (IDLE).
REQ-019 Accepted MTHI/MTLO in IDLE: write a into hi (MTHI) or lo (MTLO) at that same edge; other register unchanged; busy and done stay 0.
REQ-020 hi/lo hold their value at all times except at REQ-016/REQ-019 writes and reset.
REQ-021 MULTU: {hi,lo} = a*b as unsigned 2*WIDTH-bit product (shift-add).
REQ-022 MULT: operate on magnitudes; negate the 2*WIDTH-bit product in FIX when a[WIDTH-1] XOR b[WIDTH-1].
REQ-023 DIVU: restoring division; lo = quotient, hi = remainder.
REQ-024 DIV: divide magnitudes, truncate toward zero; in FIX negate quotient if signs differ and negate remainder if a is negative.
REQ-025 Magnitude of the most-negative value is 2^(WIDTH-1) as unsigned; DIV most-negative / -1 gives lo = most-negative, hi = 0, with no exception.
REQ-026 Divide by zero (DIV or DIVU): lo = all ones, hi = a (raw value, no sign fix-up); same WIDTH+1 latency; no flag.
REQ-027 Internal datapath width: 2*WIDTH accumulator plus WIDTH+1-bit subtractor; no truncation before FIX.

Reset
REQ-028 Reset at an edge forces state IDLE, busy=0, done=0, hi=0, lo=0 and counter=0, overriding any concurrent start.
REQ-029 Reset mid-RUN or in FIX abandons the operation; no done pulse follows and hi/lo read 0.
REQ-030 First start is accepted at the first edge after reset deasserts.

Verification (WIDTH=32)
REQ-031 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001; done exactly 33 edges after the accepting edge, one cycle wide; busy high for 33 cycles.
REQ-032 MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; MULT a=0x80000000 b=0x80000000 -> hi=0x40000000 lo=0.
REQ-033 DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000 hi=0; DIVU 7/0 -> lo=0xFFFFFFFF hi=7.
REQ-034 Busy handling: start DIVU 100/7, then a second start plus MTHI 0xDEAD while busy -> both ignored; result lo=14 hi=2.
REQ-035 MTLO a=0x12345678 in IDLE -> lo=0x12345678 after the edge, hi unchanged, busy=0, done=0; then an MTHI/start pulse on the done cycle is accepted.
REQ-036 Reset at RUN cycle 10 -> next cycle busy=0 done=0 hi=0 lo=0; no done in the following 40 cycles.
